lowtohigh_delay_ctrl: RTL and testbench



---
 rtl/delay_test_pkg.sv | 13 +
 rtl/sync2.sv | 18 +
 rtl/lowtohigh_delay_ctrl.sv | 105 ++++++++++
 tb/tb_lowtohigh_delay_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/delay_test_pkg.sv
// Shared definitions for the low-to-high and high-to-low delay test controllers.
package delay_test_pkg;
  localparam int CNT_W_DEFAULT = 8;
  localparam int SYNC_STAGES   = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_LOAD    = 3'd3,
    ST_FIN     = 3'd4
  } state_e;
endpackage

// File: rtl/sync2.sv
// Multi-flop synchroniser for a single asynchronous bit; depth comes from the package.
module sync2
  import delay_test_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/lowtohigh_delay_ctrl.sv
// Low-to-high delay test controller: settle low, launch a rising edge,
// count cycles until it returns through the synchroniser, then strobe the result.
module lowtohigh_delay_ctrl
  import delay_test_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             path_result,
  output logic             path_input,
  output logic             ld_reg,
  output logic             fin,
  output logic             timeout,
  output logic [CNT_W-1:0] delay_cnt,
  output logic             busy
);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_VAL      = CNT_W'(TIMEOUT_CYC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic             tout_q, tout_d;
  logic             res_s;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (path_result),
    .q_o   (res_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      cnt_q    <= '0;
      dly_q    <= '0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      dly_q    <= dly_d;
      tout_q   <= tout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    dly_d    = dly_q;
    tout_d   = tout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      ST_SETTLE: begin
        // Any high sample restarts the run of consecutive low cycles.
        if (res_s) begin
          settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = ST_MEASURE;
          cnt_d   = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_MEASURE: begin
        if (res_s) begin
          state_d = ST_LOAD;
          dly_d   = cnt_q;
          tout_d  = 1'b0;
        end else if (cnt_q == TO_VAL) begin
          state_d = ST_LOAD;
          dly_d   = TO_VAL;
          tout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD: state_d = ST_FIN;
      ST_FIN: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign path_input = (state_q == ST_MEASURE) || (state_q == ST_LOAD);
  assign ld_reg     = (state_q == ST_LOAD);
  assign fin        = (state_q == ST_FIN);
  assign busy       = (state_q != ST_IDLE);
  assign timeout    = tout_q;
  assign delay_cnt  = dly_q;
endmodule

// File: tb/tb_lowtohigh_delay_ctrl.sv
// Directed plus randomized bench for lowtohigh_delay_ctrl against an arithmetic timing model.
module tb_lowtohigh_delay_ctrl;
  localparam int CNT_W       = 8;
  localparam int SETTLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 255;
  localparam int SYNC_LAT    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             path_result = 1'b0;
  logic             path_input, ld_reg, fin, timeout, busy;
  logic [CNT_W-1:0] delay_cnt;

  int checks = 0;
  int passed = 0;
  int prev_dly = 0;

  lowtohigh_delay_ctrl #(
    .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .path_result(path_result),
    .path_input(path_input), .ld_reg(ld_reg), .fin(fin), .timeout(timeout),
    .delay_cnt(delay_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Cycles spent in SETTLE: the returned value lags path_result by SYNC_LAT and
  // SETTLE_CYC consecutive lows are needed once it is seen low.
  function automatic int exp_settle(input bit pre_high, input int n);
    return pre_high ? n + SYNC_LAT + SETTLE_CYC : SETTLE_CYC;
  endfunction

  // Edge returns in MEASURE cycle r (launch is cycle 0); seen SYNC_LAT later.
  function automatic int exp_delay(input int r);
    return (r + SYNC_LAT <= TIMEOUT_CYC) ? r + SYNC_LAT : TIMEOUT_CYC;
  endfunction

  function automatic bit exp_tout(input int r);
    return (r + SYNC_LAT > TIMEOUT_CYC);
  endfunction

  task automatic run_meas(input string tag, input bit pre_high, input int n,
                          input int r, input int hold);
    int c, m, ok_cnt, ed;
    ed = exp_delay(r);
    path_result = pre_high;
    repeat (3) tick;
    chk({tag, ":idle_busy"}, busy, 0);
    start = 1'b1;
    tick;
    chk({tag, ":settle_busy"}, busy, 1);
    chk({tag, ":old_dly"}, delay_cnt, prev_dly);
    c = 0;
    while (path_input === 1'b0 && c < 2000) begin
      path_result = pre_high && (c < n);
      tick;
      c++;
    end
    chk({tag, ":settle_len"}, c, exp_settle(pre_high, n));
    if (hold == 0) start = 1'b0;
    m = 0;
    while (ld_reg !== 1'b1 && m < 600) begin
      path_result = (m >= r);
      tick;
      m++;
    end
    chk({tag, ":meas_len"}, m, ed + 1);
    chk({tag, ":load_dly"}, delay_cnt, ed);
    chk({tag, ":load_tout"}, timeout, exp_tout(r));
    chk({tag, ":load_pin"}, path_input, 1);
    tick;
    chk({tag, ":ld_one_cycle"}, ld_reg, 0);
    chk({tag, ":fin"}, fin, 1);
    chk({tag, ":fin_pin"}, path_input, 0);
    ok_cnt = 0;
    for (int i = 0; i < hold; i++) begin
      tick;
      if (fin === 1'b1 && path_input === 1'b0 && ld_reg === 1'b0 && timeout === exp_tout(r))
        ok_cnt++;
    end
    if (hold > 0) chk({tag, ":fin_hold"}, ok_cnt, hold);
    start = 1'b0;
    tick;
    chk({tag, ":fin_drop"}, fin, 0);
    chk({tag, ":idle_dly"}, delay_cnt, ed);
    prev_dly = ed;
  endtask

  initial begin
    int c;
    #3;
    chk("rst:pin", path_input, 0);
    chk("rst:ld", ld_reg, 0);
    chk("rst:fin", fin, 0);
    chk("rst:tout", timeout, 0);
    chk("rst:dly", delay_cnt, 0);
    chk("rst:busy", busy, 0);
    #9 rst_n = 1'b1;
    tick;

    run_meas("nominal", 1'b0, 0, 5, 0);

    // Asynchronous reset while the launch edge is being driven.
    path_result = 1'b0;
    repeat (3) tick;
    start = 1'b1;
    c = 0;
    while (path_input === 1'b0 && c < 100) begin tick; c++; end
    repeat (2) tick;
    chk("mrst:pin_pre", path_input, 1);
    start = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("mrst:pin", path_input, 0);
    chk("mrst:busy", busy, 0);
    chk("mrst:ld", ld_reg, 0);
    chk("mrst:fin", fin, 0);
    chk("mrst:dly", delay_cnt, 0);
    chk("mrst:tout", timeout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (ld_reg === 1'b0 && busy === 1'b0 && path_input === 1'b0) c++;
    end
    chk("mrst:quiet", c, 5);
    prev_dly = 0;

    run_meas("unsettled", 1'b1, 6, 5, 0);
    run_meas("timeout", 1'b0, 0, 1000, 0);
    run_meas("stuck", 1'b0, 0, 0, 0);
    run_meas("handshake", 1'b0, 0, 9, 10);
    run_meas("edge253", 1'b0, 0, TIMEOUT_CYC - SYNC_LAT, 1);
    run_meas("edge254", 1'b1, 0, TIMEOUT_CYC - SYNC_LAT + 1, 0);

    for (int k = 0; k < 6; k++) begin
      run_meas($sformatf("rand%0d", k), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 8)), int'($urandom_range(0, 260)),
               int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
